// File: rtl/sabiranje_pkg.sv
// rtl/sabiranje_pkg.sv - shared op encoding and FSM state type for the digit-serial adder
package sabiranje_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sabirac_blok.sv
// rtl/sabirac_blok.sv - combinational K-bit chunk adder with carry-out and carry into its top bit
module sabirac_blok #(
    parameter int K = 2
) (
    input  logic [K-1:0] x,
    input  logic [K-1:0] y,
    input  logic         cin,
    output logic [K-1:0] s,
    output logic         cout,
    output logic         c_msb
);

    logic [K:0] full;

    // Full-width sum; the top sum bit recovers the carry that entered bit K-1.
    always_comb begin
        full  = {1'b0, x} + {1'b0, y} + {{K{1'b0}}, cin};
        s     = full[K-1:0];
        cout  = full[K];
        c_msb = full[K-1] ^ x[K-1] ^ y[K-1];
    end

endmodule

// File: rtl/sabiranje_sekv.sv
// rtl/sabiranje_sekv.sv - digit-serial add/subtract unit with carry, overflow, zero and saturation
module sabiranje_sekv
    import sabiranje_pkg::*;
#(
    parameter int W = 8,
    parameter int K = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    input  logic         sat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] z,
    output logic         carry,
    output logic         overflow,
    output logic         zero
);

    localparam int N  = W / K;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (W < 2 || K < 1 || K > W || (W % K) != 0) begin : g_param_check
        $error("sabiranje_sekv: need W >= 2, 1 <= K <= W and W a multiple of K");
    end

    state_t          state;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    sum_r;
    logic            c;
    logic            sat_r;
    logic            a_msb_r;
    logic [CW-1:0]   cnt;

    logic [K-1:0]    chunk_s;
    logic            chunk_cout;
    logic            chunk_c_msb;
    logic [W-1:0]    raw_sum;
    logic [W-1:0]    sat_val;
    logic [W-1:0]    final_z;
    logic            ovf;
    logic            last_chunk;

    sabirac_blok #(.K(K)) u_blok (
        .x     (a_r[cnt*K +: K]),
        .y     (b_r[cnt*K +: K]),
        .cin   (c),
        .s     (chunk_s),
        .cout  (chunk_cout),
        .c_msb (chunk_c_msb)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Merge the current chunk into the partial sum and form the saturated result;
    // on the last chunk the chunk adder's c_msb is the carry into bit W-1.
    always_comb begin
        raw_sum                = sum_r;
        raw_sum[cnt*K +: K]    = chunk_s;
        last_chunk             = (cnt == CW'(N - 1));
        ovf                    = chunk_c_msb ^ chunk_cout;
        sat_val                = a_msb_r ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        final_z                = (sat_r && ovf) ? sat_val : raw_sum;
    end

    // Control FSM with operand capture, chunk accumulation and flag registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            sum_r    <= '0;
            c        <= 1'b0;
            sat_r    <= 1'b0;
            a_msb_r  <= 1'b0;
            cnt      <= '0;
            z        <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= (op == OP_SUB) ? ~b : b;
                        c       <= op;
                        cnt     <= '0;
                        sat_r   <= sat;
                        a_msb_r <= a[W-1];
                        sum_r   <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_r <= raw_sum;
                    c     <= chunk_cout;
                    cnt   <= cnt + CW'(1);
                    if (last_chunk) begin
                        z        <= final_z;
                        carry    <= chunk_cout;
                        overflow <= ovf;
                        zero     <= (final_z == '0);
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sabiranje_sekv.sv
// tb/tb_sabiranje_sekv.sv - self-checking bench for sabiranje_sekv at (8,2), (7,7) and (8,1)
module tb_sabiranje_sekv;

    typedef struct packed {
        logic [7:0] z;
        logic       c;
        logic       v;
        logic       zr;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] in_valid_s;
    logic [2:0] op_s;
    logic [2:0] sat_s;
    logic [2:0] out_ready_s;
    logic [7:0] a_s [3];
    logic [7:0] b_s [3];
    wire  [2:0] in_ready_s;
    wire  [2:0] out_valid_s;
    wire  [2:0] carry_s;
    wire  [2:0] ovf_s;
    wire  [2:0] zero_s;
    wire  [7:0] z0;
    wire  [6:0] z1;
    wire  [7:0] z2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sabiranje_sekv #(.W(8), .K(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .a(a_s[0]), .b(b_s[0]), .op(op_s[0]), .sat(sat_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .z(z0), .carry(carry_s[0]), .overflow(ovf_s[0]), .zero(zero_s[0])
    );

    sabiranje_sekv #(.W(7), .K(7)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .a(a_s[1][6:0]), .b(b_s[1][6:0]), .op(op_s[1]), .sat(sat_s[1]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .z(z1), .carry(carry_s[1]), .overflow(ovf_s[1]), .zero(zero_s[1])
    );

    sabiranje_sekv #(.W(8), .K(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
        .a(a_s[2]), .b(b_s[2]), .op(op_s[2]), .sat(sat_s[2]),
        .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]),
        .z(z2), .carry(carry_s[2]), .overflow(ovf_s[2]), .zero(zero_s[2])
    );

    function automatic int w_of(input int d);
        return (d == 1) ? 7 : 8;
    endfunction

    function automatic int n_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 8);
    endfunction

    function automatic logic [7:0] z_of(input int d);
        return (d == 0) ? z0 : ((d == 1) ? {1'b0, z1} : z2);
    endfunction

    // Reference arithmetic: unsigned sum for carry, exact signed value for overflow/saturation.
    function automatic res_t ref_calc(input int w, input logic [7:0] a, input logic [7:0] b,
                                      input logic op, input logic sat);
        longint m, ua, ub, full, sa, sb, ex, res;
        res_t r;
        m    = longint'(1) << w;
        ua   = longint'(a) & (m - 1);
        ub   = longint'(b) & (m - 1);
        full = op ? (ua + (m - ub)) : (ua + ub);
        sa   = (ua >= m / 2) ? ua - m : ua;
        sb   = (ub >= m / 2) ? ub - m : ub;
        ex   = op ? (sa - sb) : (sa + sb);
        r.c  = (full >= m);
        r.v  = (ex > m / 2 - 1) || (ex < -(m / 2));
        if (sat && r.v) res = (ex > 0) ? (m / 2 - 1) : (m / 2);
        else            res = full % m;
        r.z  = res[7:0];
        r.zr = (res == 0);
        return r;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Behavioural model state: busy flag, cycles since accept, pending result.
    bit   m_busy [3];
    int   m_cnt  [3];
    res_t m_res  [3];

    // Timing model: result appears N+1 cycles after accept and waits for out_ready.
    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                m_busy[d] <= 1'b0;
                m_cnt[d]  <= 0;
            end else if (!m_busy[d]) begin
                if (in_valid_s[d]) begin
                    m_busy[d] <= 1'b1;
                    m_cnt[d]  <= 1;
                    m_res[d]  <= ref_calc(w_of(d), a_s[d], b_s[d], op_s[d], sat_s[d]);
                end
            end else if (m_cnt[d] < n_of(d) + 1) begin
                m_cnt[d] <= m_cnt[d] + 1;
            end else if (out_ready_s[d]) begin
                m_busy[d] <= 1'b0;
            end
        end
    end

    // Per-cycle comparison of every DUT against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                chk($sformatf("rst_out_valid[%0d]", d), out_valid_s[d], 0);
                chk($sformatf("rst_in_ready[%0d]", d), in_ready_s[d], 1);
                chk($sformatf("rst_z[%0d]", d), z_of(d), 0);
                chk($sformatf("rst_flags[%0d]", d), {carry_s[d], ovf_s[d], zero_s[d]}, 0);
            end else begin
                chk($sformatf("out_valid[%0d]", d), out_valid_s[d],
                    (m_busy[d] && m_cnt[d] == n_of(d) + 1));
                chk($sformatf("in_ready[%0d]", d), in_ready_s[d], !m_busy[d]);
                if (m_busy[d] && m_cnt[d] == n_of(d) + 1) begin
                    chk($sformatf("z[%0d]", d), z_of(d), m_res[d].z);
                    chk($sformatf("carry[%0d]", d), carry_s[d], m_res[d].c);
                    chk($sformatf("overflow[%0d]", d), ovf_s[d], m_res[d].v);
                    chk($sformatf("zero[%0d]", d), zero_s[d], m_res[d].zr);
                end
            end
        end
    end

    // One operation: accept, measure latency, optionally stall out_ready, return to IDLE.
    task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                          input logic op, input logic sat, input int hold, output res_t got);
        int t;
        int lat;
        t = 0;
        while (!in_ready_s[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("accept_wait[%0d]", d), in_ready_s[d], 1);
        in_valid_s[d]  = 1'b1;
        a_s[d]         = a;
        b_s[d]         = b;
        op_s[d]        = op;
        sat_s[d]       = sat;
        out_ready_s[d] = (hold == 0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                in_valid_s[d] = 1'b0;
                a_s[d]        = 8'($urandom);
                b_s[d]        = 8'($urandom);
                op_s[d]       = 1'($urandom);
                sat_s[d]      = 1'($urandom);
            end
        end while (!out_valid_s[d] && lat < 40);
        chk($sformatf("latency[%0d]", d), lat, n_of(d) + 1);
        got = '{z: z_of(d), c: carry_s[d], v: ovf_s[d], zr: zero_s[d]};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk($sformatf("hold_z[%0d]", d), z_of(d), got.z);
            chk($sformatf("hold_flags[%0d]", d), {carry_s[d], ovf_s[d], zero_s[d]},
                {got.c, got.v, got.zr});
            chk($sformatf("hold_in_ready[%0d]", d), in_ready_s[d], 0);
        end
        out_ready_s[d] = 1'b1;
        @(negedge clk);
        chk($sformatf("release_in_ready[%0d]", d), in_ready_s[d], 1);
    endtask

    // Accept an operation, then pull reset after k cycles (inside RUN or DONE).
    task automatic abort_op(input int d, input int k);
        in_valid_s[d]  = 1'b1;
        a_s[d]         = 8'h3F;
        b_s[d]         = 8'h01;
        op_s[d]        = 1'b0;
        sat_s[d]       = 1'b0;
        out_ready_s[d] = 1'b0;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            in_valid_s[d] = 1'b0;
        end
        chk($sformatf("abort_busy[%0d]", d), in_ready_s[d], 0);
        #2 rst_n = 1'b0;
        #1;
        chk($sformatf("abort_out_valid[%0d]", d), out_valid_s[d], 0);
        chk($sformatf("abort_in_ready[%0d]", d), in_ready_s[d], 1);
        chk($sformatf("abort_z[%0d]", d), z_of(d), 0);
        chk($sformatf("abort_flags[%0d]", d), {carry_s[d], ovf_s[d], zero_s[d]}, 0);
        out_ready_s[d] = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("abort_no_valid[%0d]", d), out_valid_s[d], 0);
        end
    endtask

    // Literal check of one operation against hand-computed values.
    task automatic lit_op(input int d, input logic [7:0] a, input logic [7:0] b, input logic op,
                          input logic sat, input int hold, input logic [7:0] ez,
                          input logic ec, input logic ev, input logic ezr);
        res_t got;
        run_op(d, a, b, op, sat, hold, got);
        chk($sformatf("lit_z[%0d] %0h/%0h", d, a, b), got.z, ez);
        chk($sformatf("lit_carry[%0d] %0h/%0h", d, a, b), got.c, ec);
        chk($sformatf("lit_ovf[%0d] %0h/%0h", d, a, b), got.v, ev);
        chk($sformatf("lit_zero[%0d] %0h/%0h", d, a, b), got.zr, ezr);
    endtask

    initial begin
        res_t got;
        in_valid_s  = '0;
        op_s        = '0;
        sat_s       = '0;
        out_ready_s = '1;
        for (int d = 0; d < 3; d++) begin
            a_s[d] = '0;
            b_s[d] = '0;
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_in_ready[%0d]", d), in_ready_s[d], 1);
            chk($sformatf("reset_out_valid[%0d]", d), out_valid_s[d], 0);
            chk($sformatf("reset_z[%0d]", d), z_of(d), 0);
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        lit_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 0, 8'h80, 1'b0, 1'b1, 1'b0);
        lit_op(0, 8'h7F, 8'h01, 1'b0, 1'b1, 0, 8'h7F, 1'b0, 1'b1, 1'b0);
        lit_op(0, 8'h05, 8'h05, 1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b1);
        lit_op(0, 8'h80, 8'h01, 1'b1, 1'b1, 0, 8'h80, 1'b1, 1'b1, 1'b0);
        lit_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 6, 8'h00, 1'b1, 1'b0, 1'b1);
        lit_op(1, 8'h3F, 8'h01, 1'b0, 1'b0, 0, 8'h40, 1'b0, 1'b1, 1'b0);
        lit_op(1, 8'h3F, 8'h01, 1'b0, 1'b1, 2, 8'h3F, 1'b0, 1'b1, 1'b0);
        lit_op(2, 8'h3F, 8'h41, 1'b0, 1'b0, 0, 8'h80, 1'b0, 1'b1, 1'b0);
        lit_op(2, 8'h00, 8'h01, 1'b1, 1'b0, 1, 8'hFF, 1'b0, 1'b0, 1'b0);

        abort_op(0, 2);
        abort_op(2, 3);
        abort_op(1, 2);

        for (int i = 0; i < 60; i++) begin
            run_op(int'($urandom_range(0, 2)), 8'($urandom), 8'($urandom), 1'($urandom),
                   1'($urandom), int'($urandom_range(0, 3)), got);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

endmodule
